// File: rtl/mux_scan_nto1.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_nto1
// Description : N-to-1 registered channel mux with manual select and a
//               dwell-timed automatic scan over enabled channels. Define
//               MUX_SCAN_LOOP_EN to make the scan wrap continuously.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_nto1 #(
    parameter int SEL_W  = 2,
    parameter int DATA_W = 8,
    parameter int DWELL  = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [(2**SEL_W)*DATA_W-1:0] i_data,
    input  logic                         i_mode,
    input  logic [SEL_W-1:0]             i_sel,
    input  logic [(2**SEL_W)-1:0]        i_ch_en,
    input  logic                         i_start,
    output logic [DATA_W-1:0]            o_data,
    output logic [SEL_W-1:0]             o_ch,
    output logic                         o_valid,
    output logic                         o_scan_done
);

    localparam int               CH_NUM     = 2**SEL_W;
    localparam int               CNT_W      = 16;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MANUAL = 2'd1,
        S_SCAN   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [SEL_W-1:0]    ch_q, ch_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                empty_q, empty_d;
    logic                wrap_q, wrap_d;

    logic [DATA_W-1:0]   w_ch_data [CH_NUM];
    logic                w_low_found;
    logic [SEL_W-1:0]    w_low_idx;
    logic                w_next_found;
    logic [SEL_W-1:0]    w_next_idx;

    generate
        for (genvar g = 0; g < CH_NUM; g++) begin : g_unpack
            assign w_ch_data[g] = i_data[g*DATA_W +: DATA_W];
        end
    endgenerate

    // Descending search so the lowest qualifying index is the one kept.
    always_comb begin
        w_low_found  = 1'b0;
        w_low_idx    = '0;
        w_next_found = 1'b0;
        w_next_idx   = '0;
        for (int k = CH_NUM - 1; k >= 0; k--) begin
            if (i_ch_en[k]) begin
                w_low_found = 1'b1;
                w_low_idx   = SEL_W'(k);
            end
            if (i_ch_en[k] && (SEL_W'(k) > ptr_q)) begin
                w_next_found = 1'b1;
                w_next_idx   = SEL_W'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        empty_d = empty_q;
        wrap_d  = wrap_q;

        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                if (!i_mode) begin
                    state_d = S_MANUAL;
                end else if (i_start) begin
                    state_d = S_SCAN;
                    ptr_d   = w_low_idx;
                    cnt_d   = '0;
                    empty_d = !w_low_found;
                    wrap_d  = 1'b0;
                end
            end

            S_MANUAL: begin
                if (i_mode) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else begin
                    data_d  = w_ch_data[i_sel];
                    ch_d    = i_sel;
                    valid_d = i_ch_en[i_sel];
                end
            end

            S_SCAN: begin
                if (!i_mode) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end else if (empty_q) begin
                    // Nothing left to show: either the pass ended or no channel was enabled.
`ifdef MUX_SCAN_LOOP_EN
                    done_d  = 1'b1;
                    valid_d = 1'b0;
                    ptr_d   = w_low_idx;
                    cnt_d   = '0;
                    empty_d = !w_low_found;
`else
                    done_d  = 1'b1;
                    valid_d = 1'b0;
                    state_d = S_IDLE;
`endif
                end else begin
                    data_d  = w_ch_data[ptr_q];
                    ch_d    = ptr_q;
                    valid_d = 1'b1;
                    done_d  = wrap_q;
                    wrap_d  = 1'b0;
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d = '0;
                        if (w_next_found) begin
                            ptr_d = w_next_idx;
                        end else begin
`ifdef MUX_SCAN_LOOP_EN
                            ptr_d = w_low_idx;
                            if (w_low_found) begin
                                wrap_d = 1'b1;
                            end else begin
                                empty_d = 1'b1;
                            end
`else
                            empty_d = 1'b1;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            wrap_q  <= wrap_d;
        end
    end

    assign o_data      = data_q;
    assign o_ch        = ch_q;
    assign o_valid     = valid_q;
    assign o_scan_done = done_q;

endmodule
`default_nettype wire

// File: doc/mux_scan_nto1.md
# mux_scan_nto1

Parametrised N-to-1 registered multiplexer with manual and automatic scan modes, the successor to the fixed 4-to-1 combinational mux. It selects one of CH_NUM channels of DATA_W bits and presents it on a registered output with a valid flag. In scan mode an internal dwell counter steps through enabled channels, skipping masked ones. It sits between multi-channel sources (counters, sensor ports) and a single downstream consumer.

## Interface
- SEL_W, 2: select width; CH_NUM = 2**SEL_W channels (derived localparam).
- DATA_W, 8: per-channel data width.
- DWELL, 16: cycles spent on each enabled channel in scan mode; legal range 1..65535.
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_data  input  CH_NUM*DATA_W  packed channel data; channel k occupies bits [k*DATA_W +: DATA_W].
- i_mode  input  1  0 = manual select, 1 = scan.
- i_sel  input  SEL_W  channel index in manual mode.
- i_ch_en  input  CH_NUM  channel enable mask; a 0 bit excludes that channel from both modes.
- i_start  input  1  single-cycle pulse; starts a scan pass when i_mode = 1.
- o_data  output  DATA_W  registered selected data.
- o_ch  output  SEL_W  index of the channel currently driven on o_data.
- o_valid  output  1  o_data holds data from an enabled channel.
- o_scan_done  output  1  one-cycle pulse at the end of a scan pass.

## Operation
- States: IDLE, MANUAL, SCAN.
- IDLE: i_mode = 0 -> MANUAL next cycle. i_mode = 1 with i_start = 1 -> SCAN. Otherwise stay. o_valid = 0.
- MANUAL: every cycle, o_data <= channel i_sel, o_ch <= i_sel, o_valid <= i_ch_en[i_sel]. If i_mode goes 1 -> IDLE.
- SCAN entry: pointer loads lowest-index enabled channel; dwell counter clears to 0.
- SCAN: o_data <= current channel data every cycle (live tracking, not a snapshot); o_ch <= pointer; o_valid <= 1. Counter increments. When counter = DWELL-1, counter clears and pointer advances to the next higher-index enabled channel.
- End of pass: advance past the highest enabled index -> o_scan_done pulses for 1 cycle, o_valid <= 0, return to IDLE (see Configuration).
- Mask sampled on each advance. A channel disabled mid-dwell finishes its dwell; a newly enabled channel ahead of the pointer is visited.
- Mask all zero at i_start: no channel visited; o_scan_done pulses the cycle after entry; o_valid stays 0.
- i_mode cleared during SCAN: abort to IDLE next cycle, no o_scan_done, o_valid <= 0.
- i_start while already in SCAN: ignored.
- Pointer arithmetic is SEL_W bits wide; wrap from CH_NUM-1 to 0 happens only with the loop feature enabled.

## Timing
- Reset (i_rst_n low, asynchronous): state IDLE, o_data = 0, o_ch = 0, o_valid = 0, o_scan_done = 0, counter = 0, pointer = 0. Outputs clear immediately on assertion; release is synchronised to the next i_clk edge.
- Latency: 1 cycle from i_data/i_sel/i_ch_en change to o_data/o_ch/o_valid.
- Scan start: i_start sampled at edge t; first channel appears on o_data after edge t+1.
- Each enabled channel is shown for exactly DWELL consecutive cycles. With E enabled channels, a pass takes E*DWELL cycles from first o_valid to o_scan_done.
- o_scan_done asserts in the cycle after the last dwell cycle, coincident with o_valid falling.

## Configuration
- MUX_SCAN_LOOP_EN defined: at end of pass the pointer wraps to the lowest enabled channel and stays in SCAN. o_scan_done pulses at each wrap; o_valid remains 1. Scan exits only when i_mode = 0 or on reset.
- MUX_SCAN_LOOP_EN undefined: single pass, then IDLE as described in Operation.

## Test plan
- Reset: assert i_rst_n = 0 mid-scan -> all outputs 0 in the same cycle; IDLE after release.
- Manual select: i_mode = 0, mask 4'b1111, i_data = {8'hDD,8'hCC,8'hBB,8'hAA}, sweep i_sel 0..3 -> o_data AA, BB, CC, DD one cycle after each i_sel change. With mask bit 2 = 0 and i_sel = 2 -> o_valid = 0.
- Full scan, DWELL = 4, mask 4'b1111, i_start pulse -> o_ch 0,1,2,3 for 4 cycles each; o_scan_done pulses after 16 valid cycles.
- Masked scan, mask 4'b1010 -> only channels 1 and 3 visited, 4 cycles each; o_scan_done after 8 valid cycles. Mask 4'b0000 -> o_scan_done one cycle after entry, o_valid never asserts.
- Abort: clear i_mode during channel 2 dwell -> o_valid = 0 next cycle, no o_scan_done pulse.
- With MUX_SCAN_LOOP_EN defined, 3 passes, mask 4'b1111 -> o_scan_done pulses every 16 cycles; o_ch sequence 3 -> 0 at each wrap; o_valid stays 1.
